// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: parity mode codes,
// FSM state encoding and the parity-bit function.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MAX_PAYLOAD = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            PAR_EVEN: en = 1'b1;
            PAR_ODD:  en = 1'b1;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

    // Payload is zero-extended to MAX_PAYLOAD bits; extra zeros do not change parity.
    function automatic logic parity_bit(input logic [MAX_PAYLOAD-1:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake between the CPU side (master) and the UART transmitter (slave).
interface uart_tx_fifo_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];
    // A flush drops any same-cycle push; the head may still be popped on that cycle.
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty;

    // Pointer update: flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (flush) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, run-time divider, optional parity,
// 1/2 stop bits and CTS gating of frame starts; frames queue back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_BITS     = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 bus,
    input  logic                          flush,
    input  logic [DIV_BITS-1:0]           divider,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          cts_n,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BIT_W = $clog2(PAYLOAD_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);

    uart_state_t              state_r, state_n;
    logic [DIV_BITS-1:0]      cnt_r, cnt_n;
    logic [DIV_BITS-1:0]      div_r;
    logic [BIT_W-1:0]         bit_r, bit_n;
    logic [PAYLOAD_BITS-1:0]  shift_r, shift_n;
    logic                     txd_r, txd_n;
    logic                     par_en_r, par_bit_r, two_stop_r;
    logic                     avail_r;
    logic                     launch_s;
    logic                     can_launch_s;
    logic                     bit_end_s;
    logic                     fifo_full_s, fifo_empty_s;
    logic [PAYLOAD_BITS-1:0]  head_s;
    logic [MAX_PAYLOAD-1:0]   head_ext_s;

    uart_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.tx_valid),
        .push_data (bus.tx_data),
        .pop       (launch_s),
        .pop_data  (head_s),
        .flush     (flush),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level)
    );

    assign bus.tx_ready = !fifo_full_s;
    assign uart_txd     = txd_r;
    assign busy         = (state_r != ST_IDLE) || !fifo_empty_s;
    assign bit_end_s    = (cnt_r == div_r);
    // avail_r is the registered not-empty status; the live flag still guards a pop.
    assign can_launch_s = avail_r && !fifo_empty_s && !cts_n;

    // Zero-extend the FIFO head for the parity helper.
    always_comb begin
        head_ext_s = {MAX_PAYLOAD{1'b0}};
        head_ext_s[PAYLOAD_BITS-1:0] = head_s;
    end

    // Next-state, bit counter, shifter and serial output.
    always_comb begin
        state_n  = state_r;
        cnt_n    = bit_end_s ? {DIV_BITS{1'b0}} : cnt_r + DIV_BITS'(1);
        bit_n    = bit_r;
        shift_n  = shift_r;
        txd_n    = txd_r;
        launch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n = {DIV_BITS{1'b0}};
                txd_n = 1'b1;
                if (can_launch_s) begin
                    launch_s = 1'b1;
                    shift_n  = head_s;
                    state_n  = ST_START;
                    txd_n    = 1'b0;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_n = ST_DATA;
                    bit_n   = {BIT_W{1'b0}};
                    txd_n   = shift_r[0];
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_r == LAST_BIT)) begin
                    bit_n   = {BIT_W{1'b0}};
                    state_n = par_en_r ? ST_PARITY : ST_STOP;
                    txd_n   = par_en_r ? par_bit_r : 1'b1;
                end else if (bit_end_s) begin
                    bit_n   = bit_r + BIT_W'(1);
                    shift_n = {1'b0, shift_r[PAYLOAD_BITS-1:1]};
                    txd_n   = shift_r[1];
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_n = ST_STOP;
                    bit_n   = {BIT_W{1'b0}};
                    txd_n   = 1'b1;
                end else begin
                    state_n = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && two_stop_r && (bit_r == {BIT_W{1'b0}})) begin
                    bit_n   = BIT_W'(1);
                    txd_n   = 1'b1;
                end else if (bit_end_s && can_launch_s) begin
                    launch_s = 1'b1;
                    shift_n  = head_s;
                    state_n  = ST_START;
                    txd_n    = 1'b0;
                end else if (bit_end_s) begin
                    state_n = ST_IDLE;
                    txd_n   = 1'b1;
                end else begin
                    state_n = ST_STOP;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {DIV_BITS{1'b0}};
                txd_n   = 1'b1;
            end
        endcase
    end

    // State and datapath registers; frame configuration is captured only at launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {DIV_BITS{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            shift_r    <= {PAYLOAD_BITS{1'b0}};
            txd_r      <= 1'b1;
            div_r      <= {DIV_BITS{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            two_stop_r <= 1'b0;
            avail_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            txd_r   <= txd_n;
            avail_r <= !fifo_empty_s;
            if (launch_s) begin
                div_r      <= divider;
                par_en_r   <= parity_enabled(parity_mode);
                par_bit_r  <= parity_bit(head_ext_s, parity_mode);
                two_stop_r <= two_stop;
            end else begin
                div_r      <= div_r;
                par_en_r   <= par_en_r;
                par_bit_r  <= par_bit_r;
                two_stop_r <= two_stop_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: hand-computed serial frames, FIFO flags,
// CTS gating, flush and reset behaviour.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [11:0] divider;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        cts_n;
    logic        uart_txd;
    logic        busy;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo_if #(.PAYLOAD_BITS(8)) bus ();

    uart_tx_fifo #(
        .PAYLOAD_BITS (8),
        .FIFO_DEPTH   (4),
        .DIV_BITS     (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush       (flush),
        .divider     (divider),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .cts_n       (cts_n),
        .uart_txd    (uart_txd),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        for (int i = 0; i < 200; i++) begin
            if (bus.tx_ready === 1'b1) break;
            tick();
        end
        chk("push_ready", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (uart_txd === 1'b0) break;
            tick();
        end
        chk("start_seen", {31'd0, uart_txd}, 32'd0);
    endtask

    // Called on the first cycle of the start bit; checks every cycle of the frame.
    task automatic frame(input string tag, input logic [7:0] d, input int div,
                         input bit has_par, input logic par, input bit two);
        logic bits [12];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (has_par) begin
            bits[n] = par;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (two) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c <= div; c++) begin
                chk($sformatf("%s_bit%0d_cyc%0d", tag, b, c), {31'd0, uart_txd}, {31'd0, bits[b]});
                tick();
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        divider      = 12'd3;
        parity_mode  = PAR_NONE;
        two_stop     = 1'b0;
        cts_n        = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        chk("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);

        // 1: 0x55, divider 3, no parity, one stop; exact launch latency.
        push(8'h55);
        chk("t1_level", {29'd0, fifo_level}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_lat_e1", {31'd0, uart_txd}, 32'd1);
        tick();
        chk("t1_lat_e1b", {31'd0, uart_txd}, 32'd1);
        tick();
        frame("t1", 8'h55, 3, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_txd_end", {31'd0, uart_txd}, 32'd1);

        // 2: parity even/odd on 0xA3 and two stop bits; config changed mid-frame.
        divider     = 12'd1;
        parity_mode = PAR_EVEN;
        push(8'hA3);
        wait_start(10);
        frame("t2_even", 8'hA3, 1, 1'b1, 1'b0, 1'b0);
        parity_mode = PAR_ODD;
        push(8'hA3);
        wait_start(10);
        divider     = 12'd7;
        parity_mode = PAR_NONE;
        two_stop    = 1'b1;
        frame("t2_odd", 8'hA3, 1, 1'b1, 1'b1, 1'b0);
        divider = 12'd1;
        push(8'hA3);
        wait_start(10);
        frame("t2_2stop", 8'hA3, 1, 1'b0, 1'b0, 1'b1);
        two_stop = 1'b0;
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // 3: six bytes at divider 0; full FIFO, contiguous frames.
        divider = 12'd0;
        cts_n   = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("t3_full_ready", {31'd0, bus.tx_ready}, 32'd0);
        chk("t3_full_level", {29'd0, fifo_level}, 32'd4);
        chk("t3_full_txd", {31'd0, uart_txd}, 32'd1);
        cts_n = 1'b0;
        fork
            begin
                push(8'h55);
                chk("t3_refull_ready", {31'd0, bus.tx_ready}, 32'd0);
                chk("t3_refull_level", {29'd0, fifo_level}, 32'd4);
                push(8'h66);
            end
            begin
                tick();
                frame("t3_f0", 8'h11, 0, 1'b0, 1'b0, 1'b0);
                frame("t3_f1", 8'h22, 0, 1'b0, 1'b0, 1'b0);
                frame("t3_f2", 8'h33, 0, 1'b0, 1'b0, 1'b0);
                frame("t3_f3", 8'h44, 0, 1'b0, 1'b0, 1'b0);
                frame("t3_f4", 8'h55, 0, 1'b0, 1'b0, 1'b0);
                frame("t3_f5", 8'h66, 0, 1'b0, 1'b0, 1'b0);
            end
        join
        chk("t3_level_end", {29'd0, fifo_level}, 32'd0);
        chk("t3_busy_end", {31'd0, busy}, 32'd0);
        chk("t3_txd_end", {31'd0, uart_txd}, 32'd1);

        // 4: CTS holds frames off; raised mid-frame it blocks only the next one.
        divider = 12'd1;
        cts_n   = 1'b1;
        push(8'h0F); push(8'hF0);
        for (int i = 0; i < 20; i++) tick();
        chk("t4_held_txd", {31'd0, uart_txd}, 32'd1);
        chk("t4_held_level", {29'd0, fifo_level}, 32'd2);
        cts_n = 1'b0;
        tick();
        cts_n = 1'b1;
        frame("t4_f0", 8'h0F, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_wait_txd", {31'd0, uart_txd}, 32'd1);
        chk("t4_wait_level", {29'd0, fifo_level}, 32'd1);
        cts_n = 1'b0;
        tick();
        frame("t4_f1", 8'hF0, 1, 1'b0, 1'b0, 1'b0);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);

        // 5: flush (with a colliding push) during frame 1 of 4.
        cts_n = 1'b1;
        push(8'hC3); push(8'h3C); push(8'h5A); push(8'hA5);
        cts_n = 1'b0;
        tick();
        fork
            begin
                chk("t5_level_after_pop", {29'd0, fifo_level}, 32'd3);
                tick();
                flush        = 1'b1;
                bus.tx_data  = 8'hEE;
                bus.tx_valid = 1'b1;
                tick();
                flush        = 1'b0;
                bus.tx_valid = 1'b0;
                chk("t5_flush_level", {29'd0, fifo_level}, 32'd0);
                chk("t5_flush_ready", {31'd0, bus.tx_ready}, 32'd1);
            end
            frame("t5_f0", 8'hC3, 1, 1'b0, 1'b0, 1'b0);
        join
        chk("t5_busy_end", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_no_more_txd", {31'd0, uart_txd}, 32'd1);
        chk("t5_no_more_level", {29'd0, fifo_level}, 32'd0);

        // 6: reset during a data bit, then a fresh frame.
        divider = 12'd3;
        push(8'h00); push(8'h00);
        wait_start(10);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_mid_data", {31'd0, uart_txd}, 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_rst_txd", {31'd0, uart_txd}, 32'd1);
        chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("t6_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_resume", {31'd0, uart_txd}, 32'd1);
        divider     = 12'd2;
        parity_mode = PAR_ODD;
        push(8'hC5);
        chk("t6_lat_a", {31'd0, uart_txd}, 32'd1);
        tick();
        chk("t6_lat_b", {31'd0, uart_txd}, 32'd1);
        tick();
        frame("t6_f", 8'hC5, 2, 1'b1, 1'b1, 1'b0);
        chk("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
